// File: rtl/difference_n_bits_decode.sv
// First-difference decoder for a running-sum stream: recovers per-sample increments
// modulo 2^N and flags borrow, signed overflow and carry/borrow disagreement.
module difference_n_bits_decode #(
    parameter int N  = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          aclr_n,
    input  logic          restart,
    input  logic          in_valid,
    input  logic [N-1:0]  S_in,
    input  logic          carry_in,
    output logic          out_valid,
    output logic [N-1:0]  D,
    output logic          borrow,
    output logic          overflow,
    output logic          mismatch,
    output logic [CW-1:0] count
);

    typedef enum logic {EMPTY = 1'b0, PRIMED = 1'b1} state_t;

    state_t      state, state_nxt;
    logic [N-1:0] prev;
    logic [N:0]   diff;
    logic         emit;
    logic         load_prev;

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) state <= EMPTY;
        else         state <= state_nxt;
    end

    // restart with a valid sample re-primes on that sample instead of emptying
    always_comb begin
        state_nxt = state;
        if (restart)       state_nxt = in_valid ? PRIMED : EMPTY;
        else if (in_valid) state_nxt = PRIMED;
    end

    always_comb begin
        load_prev = in_valid;
        emit      = in_valid && !restart && (state == PRIMED);
    end

    assign diff = {1'b0, S_in} - {1'b0, prev};

    always_ff @(posedge clk or negedge aclr_n) begin
        if (!aclr_n) begin
            prev      <= '0;
            out_valid <= 1'b0;
            D         <= '0;
            borrow    <= 1'b0;
            overflow  <= 1'b0;
            mismatch  <= 1'b0;
            count     <= '0;
        end else begin
            out_valid <= emit;
            if (load_prev) prev <= S_in;
            if (emit) begin
                D        <= diff[N-1:0];
                borrow   <= diff[N];
                overflow <= (S_in[N-1] != prev[N-1]) && (diff[N-1] != S_in[N-1]);
                mismatch <= diff[N] ^ carry_in;
            end
            // counter saturates rather than wrapping
            if (restart)                     count <= '0;
            else if (emit && (count != '1))  count <= count + CW'(1);
        end
    end

endmodule
